// File: rtl/addsub_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_accumulator
//
// Accumulator stage that sits downstream of an N-bit add/subtract unit. The
// running value is kept in a register and fed back as one addend. Ops arrive
// over a valid/ready handshake, and each accepted op updates the accumulator
// once. The result, with carry/borrow and signed-overflow flags, is presented
// through a one-entry output slot with its own valid/ready handshake.
//
// Parameters:
//   N_BITS   : data / accumulator width (min 2)
//   CNT_BITS : width of the saturating accepted-op counter
//
// Ports:
//   clk             : rising-edge clock
//   reset           : synchronous, active-high reset
//   in_valid        : op/operand valid
//   in_ready        : stage can accept an op this cycle
//   in_op           : 00=ADD, 01=SUB, 10=LOAD, 11=CLEAR
//   in_data         : operand
//   out_valid       : result slot full
//   out_ready       : downstream consumes the result
//   out_data        : accumulator value after the op
//   out_carry       : carry of the last ADD/SUB (for SUB, 1 = no borrow)
//   out_overflow    : signed overflow of the last op
//   sticky_overflow : OR of out_overflow since reset/CLEAR
//   op_count        : accepted ops since reset/CLEAR, saturating
// -----------------------------------------------------------------------------
module addsub_accumulator #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [N_BITS-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_BITS-1:0]   out_data,
  output logic                out_carry,
  output logic                out_overflow,
  output logic                sticky_overflow,
  output logic [CNT_BITS-1:0] op_count
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam int MSB = N_BITS - 1;

  logic [N_BITS-1:0]   r_acc;
  logic                r_carry;
  logic                r_ovf;
  logic                r_sticky;
  logic [CNT_BITS-1:0] r_count;
  logic                r_valid;

  op_e                 w_op;
  logic                w_accept;
  logic                w_is_sub;
  logic [N_BITS-1:0]   w_operand;
  logic [N_BITS:0]     w_sum;
  logic [N_BITS-1:0]   w_res;
  logic                w_carry;
  logic                w_ovf;

  assign w_op     = op_e'(in_op);
  // A full slot can still accept when it is being drained in the same cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Single adder serves both ADD and SUB: subtraction is a + ~d + 1.
  assign w_is_sub  = (w_op == OP_SUB);
  assign w_operand = w_is_sub ? ~in_data : in_data;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_operand} + {{N_BITS{1'b0}}, w_is_sub};

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_res   = w_sum[MSB:0];
    w_carry = w_sum[N_BITS];
    w_ovf   = 1'b0;
    case (w_op)
      OP_ADD:   w_ovf = (r_acc[MSB] == in_data[MSB]) && (w_res[MSB] != r_acc[MSB]);
      OP_SUB:   w_ovf = (r_acc[MSB] != in_data[MSB]) && (w_res[MSB] != r_acc[MSB]);
      OP_LOAD: begin
        w_res   = in_data;
        w_carry = 1'b0;
      end
      OP_CLEAR: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      // A new result overwrites the slot, even when the old one is consumed
      // on this same edge.
      r_acc   <= w_res;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
      r_valid <= 1'b1;
      if (w_op == OP_CLEAR) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
      end else begin
        r_sticky <= r_sticky | w_ovf;
        if (r_count != {CNT_BITS{1'b1}}) begin
          r_count <= r_count + CNT_BITS'(1);
        end
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid       = r_valid;
  assign out_data        = r_acc;
  assign out_carry       = r_carry;
  assign out_overflow    = r_ovf;
  assign sticky_overflow = r_sticky;
  assign op_count        = r_count;

endmodule

// File: tb/tb_addsub_accumulator.sv
// -----------------------------------------------------------------------------
// tb_addsub_accumulator
//
// Directed self-checking bench for addsub_accumulator (N_BITS=8, CNT_BITS=2).
// Each scenario task drives its own stimulus and compares the packed output
// vector {out_valid, out_data, out_carry, out_overflow, sticky_overflow,
// op_count} against hand-computed values. Inputs change 1 ns after the rising
// edge, and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_addsub_accumulator;

  localparam int N = 8;
  localparam int C = 2;

  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_carry;
  logic         out_overflow;
  logic         sticky_overflow;
  logic [C-1:0] op_count;

  // {valid, data, carry, overflow, sticky, count}
  logic [13:0]  obs;
  assign obs = {out_valid, out_data, out_carry, out_overflow, sticky_overflow, op_count};

  int total = 0;
  int bad   = 0;

  addsub_accumulator #(.N_BITS(N), .CNT_BITS(C)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_carry       (out_carry),
    .out_overflow    (out_overflow),
    .sticky_overflow (sticky_overflow),
    .op_count        (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus tables: op, operand, expected packed output after the edge.
  localparam logic [1:0]  ADD_OPS [3] = '{LOAD, ADD, ADD};
  localparam logic [7:0]  ADD_DS  [3] = '{8'h7F, 8'h01, 8'hFF};
  localparam logic [13:0] ADD_EX  [3] = '{
    {1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 2'd1},
    {1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 2'd2},
    {1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 2'd3}
  };

  localparam logic [1:0]  SUB_OPS [6] = '{LOAD, SUB, SUB, LOAD, SUB, CLEAR};
  localparam logic [7:0]  SUB_DS  [6] = '{8'h05, 8'h07, 8'h00, 8'h80, 8'h01, 8'h00};
  localparam logic [13:0] SUB_EX  [6] = '{
    {1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 2'd1},
    {1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 2'd2},
    {1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 2'd3},
    {1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 2'd3},
    {1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 2'd3},
    {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0}
  };

  localparam logic [1:0]  SAT_OPS [6] = '{ADD, ADD, ADD, ADD, ADD, CLEAR};
  localparam logic [13:0] SAT_EX  [6] = '{
    {1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd1},
    {1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 2'd2},
    {1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 2'd3},
    {1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 2'd3},
    {1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 2'd3},
    {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0}
  };

  // Present one op for a single edge, then withdraw it with unknown payload.
  task automatic send(input logic [1:0] op, input logic [7:0] d);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 'x;
    in_data  = 'x;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a scenario from a known state: count 0, sticky 0, slot empty.
  task automatic restart();
    out_ready = 1'b1;
    send(CLEAR, 8'h00);
    idle(1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = LOAD;
    in_data   = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 14'h0);
    end
    // Release with the LOAD still presented: nothing changes before the edge.
    reset = 1'b0;
    #1;
    total++;
    if ({in_ready, obs} !== {1'b1, 14'h0}) begin
      bad++;
      $display("FAIL post_reset_idle: got ready=%b out=%h expected ready=1 out=%h", in_ready, obs, 14'h0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 2'd1}) begin
      bad++;
      $display("FAIL first_load: got %h expected %h", obs, {1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 2'd1});
    end
    idle(1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL slot_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_add_overflow();
    restart();
    for (int i = 0; i < 3; i++) begin
      send(ADD_OPS[i], ADD_DS[i]);
      total++;
      if (obs !== ADD_EX[i]) begin
        bad++;
        $display("FAIL add_step%0d: got %h expected %h", i, obs, ADD_EX[i]);
      end
    end
  endtask

  task automatic test_sub_clear();
    restart();
    for (int i = 0; i < 6; i++) begin
      send(SUB_OPS[i], SUB_DS[i]);
      total++;
      if (obs !== SUB_EX[i]) begin
        bad++;
        $display("FAIL sub_step%0d: got %h expected %h", i, obs, SUB_EX[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    restart();
    send(LOAD, 8'h10);
    idle(1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = ADD;
    in_data   = 8'h01;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, obs} !== {1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL bp_first: got ready=%b out=%h expected ready=0 out=%h", in_ready, obs,
               {1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd2});
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== {1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL bp_hold: got %h expected %h", obs, {1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 2'd2});
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_comb: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 2'd3}) begin
      bad++;
      $display("FAIL bp_second: got %h expected %h", obs, {1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 2'd3});
    end
    idle(1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    restart();
    for (int i = 0; i < 6; i++) begin
      send(SAT_OPS[i], 8'h01);
      total++;
      if (obs !== SAT_EX[i]) begin
        bad++;
        $display("FAIL sat_step%0d: got %h expected %h", i, obs, SAT_EX[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    send(LOAD, 8'h20);
    idle(1);
    out_ready = 1'b0;
    send(SUB, 8'h01);
    total++;
    if ({in_ready, obs} !== {1'b0, 1'b1, 8'h1F, 1'b1, 1'b0, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL mid_pending: got ready=%b out=%h expected ready=0 out=%h", in_ready, obs,
               {1'b1, 8'h1F, 1'b1, 1'b0, 1'b0, 2'd2});
    end
    // Reset competes with a presented op; reset must win.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_op    = ADD;
    in_data  = 8'h05;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if ({in_ready, obs} !== {1'b1, 14'h0}) begin
      bad++;
      $display("FAIL mid_reset: got ready=%b out=%h expected ready=1 out=%h", in_ready, obs, 14'h0);
    end
    idle(1);
    total++;
    if (obs !== 14'h0) begin
      bad++;
      $display("FAIL mid_after: got %h expected %h", obs, 14'h0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub_clear();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
